ls377_xfer_ctrl: RTL and testbench

Transfer sequencer for the bank of LS377 octal registers on the model computer's shared 8-bit data bus. It arbitrates register-transfer requests from several requesters, drives the bus source select, and pulses the active-low load enable of exactly one destination LS377. Each transfer is a fixed four-phase sequence, so bus settle and capture edges are deterministic.

---
 rtl/ls377_xfer_pkg.sv | 30 +++
 rtl/ls377_xfer_arb.sv | 51 +++++
 rtl/ls377_xfer_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ls377_xfer_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls377_xfer_pkg.sv
// ls377_xfer_pkg
//   Shared types and width helpers for the LS377 transfer sequencer.
//   Contents:
//     xfer_state_e - sequencer states (IDLE, SETUP, LOAD, DONE)
//     calc_dw()    - destination index width for NREG registers
//     calc_sw()    - source code width (NREG registers plus the external DIN code)
//     calc_gw()    - requester index width for NREQ requesters
package ls377_xfer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } xfer_state_e;

   function automatic int calc_dw(input int nreg);
      return $clog2(nreg);
   endfunction

   // One extra code point above the registers selects external DIN.
   function automatic int calc_sw(input int nreg);
      return $clog2(nreg + 1);
   endfunction

   function automatic int calc_gw(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/ls377_xfer_arb.sv
// ls377_xfer_arb
//   Combinational requester arbiter for the LS377 transfer sequencer.
//   Build option: LS377_XFER_RR_EN
//     defined   - round-robin; the search starts at ptr and wraps modulo NREQ
//     undefined - fixed priority, lowest index wins (no ptr port)
//   Ports:
//     req       in  NREQ  request vector
//     ptr       in  GW    round-robin start index (LS377_XFER_RR_EN only)
//     grant_oh  out NREQ  one-hot grant
//     grant_idx out GW    encoded grant index (0 when nothing requested)
//     grant_vld out 1     any request present
module ls377_xfer_arb
   import ls377_xfer_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int GW   = calc_gw(NREQ)
) (
   input  logic [NREQ-1:0] req,
`ifdef LS377_XFER_RR_EN
   input  logic [GW-1:0]   ptr,
`endif
   output logic [NREQ-1:0] grant_oh,
   output logic [GW-1:0]   grant_idx,
   output logic            grant_vld
);

   logic [GW-1:0] idx;

   // The loop walks from the lowest-priority candidate to the highest, so
   // the last hit overwrites earlier ones and the highest priority wins.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef LS377_XFER_RR_EN
         idx = GW'((int'(ptr) + k) % NREQ);
`else
         idx = GW'(k);
`endif
         if (req[idx]) begin
            grant_oh  = '0;
            grant_oh[idx] = 1'b1;
            grant_idx = idx;
            grant_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ls377_xfer_ctrl.sv
// ls377_xfer_ctrl
//   Transfer sequencer for a bank of LS377 octal registers sharing one 8-bit
//   bus. One transfer = IDLE (arbitrate) -> SETUP (bus settles) -> LOAD (one
//   LOAD_N bit low) -> DONE (ACK pulse). All outputs are registered.
//   Build option: LS377_XFER_RR_EN selects round-robin arbitration; without it
//   the lowest requester index always wins and no pointer exists.
//   Handshake: a requester raises req[i] with its src/dst and holds all three
//   until ack[i] pulses; src/dst are captured only at the grant edge, and a
//   req still high in the IDLE cycle after ack counts as a new request.
//   Ports:
//     clk       in  1          system clock, rising edge
//     rst_n     in  1          asynchronous active-low reset
//     req       in  NREQ       per-requester request level
//     req_src   in  NREQ*SW    per-requester source code (>= NREG = DIN)
//     req_dst   in  NREQ*DW    per-requester destination register
//     ack       out NREQ       one-cycle completion pulse
//     bus_sel   out SW         bus source select
//     load_n    out NREG       LS377 enables, active-low, at most one low
//     busy      out 1          high whenever not IDLE
//     dbg_state out 2          current sequencer state
module ls377_xfer_ctrl
   import ls377_xfer_pkg::*;
#(
   parameter  int NREG = 4,
   parameter  int NREQ = 4,
   localparam int DW   = calc_dw(NREG),
   localparam int SW   = calc_sw(NREG),
   localparam int GW   = calc_gw(NREQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*SW-1:0] req_src,
   input  logic [NREQ*DW-1:0] req_dst,
   output logic [NREQ-1:0]    ack,
   output logic [SW-1:0]      bus_sel,
   output logic [NREG-1:0]    load_n,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   xfer_state_e     state_q, state_nxt;
   logic [GW-1:0]   g_q, g_nxt;
   logic [SW-1:0]   src_q, src_nxt;
   logic [DW-1:0]   dst_q, dst_nxt;
   logic [SW-1:0]   bus_sel_nxt;
   logic [NREG-1:0] load_n_nxt;
   logic [NREQ-1:0] ack_nxt;
   logic            busy_nxt;

   logic [NREQ-1:0] grant_oh;
   logic [GW-1:0]   grant_idx;
   logic            grant_vld;
   logic [SW-1:0]   win_src;
   logic [DW-1:0]   win_dst;
   logic            self_copy;

`ifdef LS377_XFER_RR_EN
   logic [GW-1:0]   ptr_q;

   ls377_xfer_arb #(.NREQ(NREQ)) u_arb (
      .req       (req),
      .ptr       (ptr_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // Pointer moves to the slot after the winner on every grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (state_q == IDLE && grant_vld) begin
         ptr_q <= (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end
`else
   ls377_xfer_arb #(.NREQ(NREQ)) u_arb (
      .req       (req),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );
`endif

   assign win_src = req_src[grant_idx*SW +: SW];
   assign win_dst = req_dst[grant_idx*DW +: DW];

   // A register copied onto itself needs no capture edge.
   assign self_copy = (src_q < SW'(NREG)) && (src_q[DW-1:0] == dst_q);

   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next state plus the values every output register takes at the next edge;
   // outputs therefore reflect the state being entered.
   always_comb begin
      state_nxt   = state_q;
      g_nxt       = g_q;
      src_nxt     = src_q;
      dst_nxt     = dst_q;
      bus_sel_nxt = bus_sel;
      load_n_nxt  = '1;
      ack_nxt     = '0;
      unique case (state_q)
         IDLE: begin
            if (grant_vld) begin
               state_nxt   = SETUP;
               g_nxt       = grant_idx;
               src_nxt     = win_src;
               dst_nxt     = win_dst;
               bus_sel_nxt = win_src;
            end
         end
         SETUP: begin
            state_nxt = LOAD;
            if (!self_copy) begin
               load_n_nxt[dst_q] = 1'b0;
            end
         end
         LOAD: begin
            state_nxt    = DONE;
            ack_nxt[g_q] = 1'b1;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q     <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         bus_sel <= '0;
         load_n  <= '1;
         ack     <= '0;
         busy    <= 1'b0;
      end else begin
         g_q     <= g_nxt;
         src_q   <= src_nxt;
         dst_q   <= dst_nxt;
         bus_sel <= bus_sel_nxt;
         load_n  <= load_n_nxt;
         ack     <= ack_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_ls377_xfer_ctrl.sv
// tb_ls377_xfer_ctrl
//   Bench for ls377_xfer_ctrl: directed scenarios with literal expectations,
//   then randomized requesters, all cross-checked every cycle against a
//   transaction-level timeline model.
module tb_ls377_xfer_ctrl;
   import ls377_xfer_pkg::*;

   localparam int NREG = 4;
   localparam int NREQ = 4;
   localparam int DW   = 2;
   localparam int SW   = 3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*SW-1:0] req_src = '0;
   logic [NREQ*DW-1:0] req_dst = '0;
   logic [NREQ-1:0]    ack;
   logic [SW-1:0]      bus_sel;
   logic [NREG-1:0]    load_n;
   logic               busy;
   logic [1:0]         dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   ls377_xfer_ctrl #(.NREG(NREG), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .ack       (ack),
      .bus_sel   (bus_sel),
      .load_n    (load_n),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input int s, input int d);
      req_src[i*SW +: SW] = SW'(s);
      req_dst[i*DW +: DW] = DW'(d);
      req[i] = 1'b1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      step();
      step();
      chk("rst_load_n", 32'(load_n), 32'hF);
      chk("rst_bus_sel", 32'(bus_sel), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'h0);
      rst_n = 1'b1;
   endtask

   // ---------------- reference model ----------------
   // Each grant schedules a four-entry output timeline (SETUP, LOAD, DONE,
   // back in IDLE); arbitration happens only when the timeline is empty.
   typedef struct packed {
      logic [SW-1:0]   sel;
      logic [NREG-1:0] ln;
      logic [NREQ-1:0] ak;
      logic            bz;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   ptr_m = 0;
   logic [SW-1:0] last_sel = '0;

   function automatic int pick_winner(input logic [NREQ-1:0] r, input int p);
`ifdef LS377_XFER_RR_EN
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
`else
      for (int k = 0; k < NREQ; k++) begin
         if (r[k]) return k;
      end
`endif
      return 0;
   endfunction

   always begin : compare_proc
      int w, s, d;
      exp_t e;
      @(posedge clk);
      if (!rst_n) begin
         exp_q.delete();
         ptr_m    = 0;
         last_sel = '0;
         cur.sel  = '0;
         cur.ln   = '1;
         cur.ak   = '0;
         cur.bz   = 1'b0;
      end else begin
         if (exp_q.size() == 0 && req != '0) begin
            w = pick_winner(req, ptr_m);
            s = int'(req_src[w*SW +: SW]);
            d = int'(req_dst[w*DW +: DW]);
            ptr_m = (w + 1) % NREQ;
            last_sel = SW'(s);
            e.sel = SW'(s); e.ln = '1; e.ak = '0; e.bz = 1'b1;
            exp_q.push_back(e);
            e.ln = (s < NREG && s == d) ? 4'hF : ~(4'h1 << d);
            exp_q.push_back(e);
            e.ln = '1; e.ak = 4'h1 << w;
            exp_q.push_back(e);
            e.ak = '0; e.bz = 1'b0;
            exp_q.push_back(e);
         end
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
         end else begin
            cur.sel = last_sel; cur.ln = '1; cur.ak = '0; cur.bz = 1'b0;
         end
      end
      #1;
      chk("m_bus_sel", 32'(bus_sel), 32'(cur.sel));
      chk("m_load_n", 32'(load_n), 32'(cur.ln));
      chk("m_ack", 32'(ack), 32'(cur.ak));
      chk("m_busy", 32'(busy), 32'(cur.bz));
   end

   // ---------------- stimulus ----------------
   int gseq[5];
   int got, cyc, idx;

   initial begin
      reset_dut();
      step();

      // DIN into register 2 from requester 1
      set_req(1, 4, 2);
      step();                                   // E0+1: SETUP
      chk("t1_setup_sel", 32'(bus_sel), 32'h4);
      chk("t1_setup_ln", 32'(load_n), 32'hF);
      chk("t1_setup_busy", 32'(busy), 32'h1);
      step();                                   // LOAD
      chk("t1_load_ln", 32'(load_n), 32'hB);
      chk("t1_load_sel", 32'(bus_sel), 32'h4);
      chk("t1_load_ack", 32'(ack), 32'h0);
      step();                                   // DONE
      chk("t1_done_ack", 32'(ack), 32'h2);
      chk("t1_done_ln", 32'(load_n), 32'hF);
      req[1] = 1'b0;
      step();                                   // IDLE
      chk("t1_idle_busy", 32'(busy), 32'h0);
      chk("t1_idle_ack", 32'(ack), 32'h0);
      step();

      // self-copy of register 3
      set_req(0, 3, 3);
      step();
      chk("t2_setup_ln", 32'(load_n), 32'hF);
      step();
      chk("t2_load_ln", 32'(load_n), 32'hF);
      step();
      chk("t2_done_ack", 32'(ack), 32'h1);
      req[0] = 1'b0;
      step();
      step();

      // all four requesting continuously
      reset_dut();
      for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(7, 0), $urandom_range(3, 0));
      got = 0;
      cyc = 0;
      while (got < 5 && cyc < 40) begin
         step();
         cyc++;
         if (ack != '0) begin
            idx = 0;
            for (int k = 0; k < NREQ; k++) if (ack[k]) idx = k;
            gseq[got] = idx;
            got++;
         end
      end
      req = '0;
      chk("t3_grant_count", 32'(got), 32'd5);
      for (int k = 0; k < 5; k++) begin
`ifdef LS377_XFER_RR_EN
         chk("t3_grant_order", 32'(gseq[k]), 32'(k % NREQ));
`else
         chk("t3_grant_order", 32'(gseq[k]), 32'd0);
`endif
      end
      repeat (5) step();

      // reset during LOAD, request held and re-served
      set_req(1, 0, 1);
      step();
      step();
      chk("t4_load_ln", 32'(load_n), 32'hD);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_async_ln", 32'(load_n), 32'hF);
      chk("t4_async_ack", 32'(ack), 32'h0);
      step();
      chk("t4_rst_ack", 32'(ack), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("t4_re_busy", 32'(busy), 32'h1);
      step();
      chk("t4_re_ln", 32'(load_n), 32'hD);
      step();
      chk("t4_re_ack", 32'(ack), 32'h2);
      req[1] = 1'b0;
      repeat (2) step();

      // source changed after grant is ignored
      set_req(2, 0, 1);
      step();
      req_src[2*SW +: SW] = 3'd2;
      chk("t5_setup_sel", 32'(bus_sel), 32'h0);
      step();
      chk("t5_load_sel", 32'(bus_sel), 32'h0);
      chk("t5_load_ln", 32'(load_n), 32'hD);
      step();
      chk("t5_done_ack", 32'(ack), 32'h4);
      req[2] = 1'b0;
      repeat (2) step();

      // req held one cycle past ack -> second transfer
      set_req(3, 1, 0);
      step();
      step();
      step();
      chk("t6_ack1", 32'(ack), 32'h8);
      step();
      chk("t6_gap_busy", 32'(busy), 32'h0);
      step();
      chk("t6_second_busy", 32'(busy), 32'h1);
      chk("t6_second_sel", 32'(bus_sel), 32'h1);
      req[3] = 1'b0;
      step();
      chk("t6_second_ln", 32'(load_n), 32'hE);
      step();
      chk("t6_ack2", 32'(ack), 32'h8);
      repeat (2) step();

      // randomized requesters
      for (int c = 0; c < 600; c++) begin
         step();
         if (c == 300) rst_n = 1'b0;
         if (c == 302) rst_n = 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
               if (ack[i]) begin
                  if ($urandom_range(3, 0) != 0) req[i] = 1'b0;
               end else if ($urandom_range(5, 0) == 0) begin
                  req_src[i*SW +: SW] = SW'($urandom_range(7, 0));
                  req_dst[i*DW +: DW] = DW'($urandom_range(3, 0));
               end
            end else if ($urandom_range(2, 0) == 0) begin
               set_req(i, $urandom_range(7, 0), $urandom_range(3, 0));
            end
         end
      end
      req = '0;
      repeat (6) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
